// File: rtl/s_down_counter_pkg.sv
// s_down_counter_pkg: JK command encodings and default width shared by the down counter.
package s_down_counter_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;
endpackage

// File: rtl/jk_ff_sr.sv
// jk_ff_sr: JK flip-flop with synchronous active-high reset to a per-instance value.
module jk_ff_sr
  import s_down_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q,
  output logic nq
);
  jk_cmd_t cmd;
  assign cmd = jk_cmd_t'({j, k});
  always_ff @(posedge clk)
    q <= rst ? rst_val :
         cmd == JK_SET    ? 1'b1 :
         cmd == JK_RESET  ? 1'b0 :
         cmd == JK_TOGGLE ? ~q : q;
  assign nq = ~q;
endmodule

// File: rtl/s_down_counter.sv
// s_down_counter: synchronous JK down counter with load, enable, zero flag and borrow pulse.
// Define S_DOWN_COUNTER_RELOAD_EN to wrap to the last loaded value instead of all ones.
module s_down_counter
  import s_down_counter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] L,
  output logic             zero,
  output logic             borrow
);
  logic [WIDTH-1:0] nq, wrap, j, k;
`ifdef S_DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload;
  always_ff @(posedge clk)
    reload <= rst ? RESET_VALUE : load ? din : reload;
  assign wrap = reload;
`else
  assign wrap = {WIDTH{1'b1}};
`endif
  assign zero = &nq;
  always_ff @(posedge clk)
    borrow <= !rst && !load && en && zero;
  // On underflow every bit is driven straight to the wrap value; otherwise the usual borrow-toggle chain.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic low_zero;
    if (i == 0) begin : g_lsb
      assign low_zero = 1'b1;
    end else begin : g_upper
      assign low_zero = &nq[i-1:0];
    end
    assign j[i] = load ? din[i]  : en & (zero ? wrap[i]  : low_zero);
    assign k[i] = load ? ~din[i] : en & (zero ? ~wrap[i] : low_zero);
    jk_ff_sr u_ff (
      .clk    (clk),
      .rst    (rst),
      .rst_val(RESET_VALUE[i]),
      .j      (j[i]),
      .k      (k[i]),
      .q      (L[i]),
      .nq     (nq[i])
    );
  end
endmodule

// File: tb/tb_s_down_counter.sv
// tb_s_down_counter: directed and random stimulus against an arithmetic reference, scoreboard-checked.
module tb_s_down_counter;
  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int RV = MAXV;

  typedef struct {
    int l;
    bit z;
    bit b;
  } exp_t;

  logic clk = 0;
  logic rst = 0, en = 0, load = 0;
  logic [W-1:0] din = '0;
  logic [W-1:0] L;
  logic zero, borrow;

  exp_t q[$];
  int total = 0, bad = 0;
  int m_l = 0, m_rl = RV;
  bit m_b = 0;

  s_down_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
    .L(L), .zero(zero), .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, input bit ld, input bit e, input int d);
    exp_t x;
    int wrapv;
    @(negedge clk);
    rst = r; load = ld; en = e; din = W'(d);
`ifdef S_DOWN_COUNTER_RELOAD_EN
    wrapv = m_rl;
`else
    wrapv = MAXV;
`endif
    if (r) begin
      m_l = RV; m_rl = RV; m_b = 0;
    end else if (ld) begin
      m_l = d & MAXV; m_rl = d & MAXV; m_b = 0;
    end else if (e) begin
      m_b = (m_l == 0);
      m_l = (m_l == 0) ? wrapv : m_l - 1;
    end else m_b = 0;
    x.l = m_l; x.z = (m_l == 0); x.b = m_b;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      total += 3;
      if (int'(L) != x.l) begin
        bad++; $display("FAIL count: got %0d want %0d at %0t", L, x.l, $time);
      end
      if (zero !== x.z) begin
        bad++; $display("FAIL zero: got %b want %b at %0t", zero, x.z, $time);
      end
      if (borrow !== x.b) begin
        bad++; $display("FAIL borrow: got %b want %b at %0t", borrow, x.b, $time);
      end
    end
  end

  initial begin
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    repeat (16) step(0, 0, 1, 0);
    step(0, 1, 1, 3);
    repeat (3) step(0, 0, 1, 0);
    step(0, 1, 1, 9);
    repeat (3) step(0, 0, 1, 0);
    step(1, 1, 1, 2);
    repeat (2) step(0, 0, 1, 0);
`ifdef S_DOWN_COUNTER_RELOAD_EN
    step(0, 1, 0, 4);
    repeat (12) step(0, 0, 1, 0);
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, MAXV)));
    step(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
